// File: rtl/cgra_red_pkg.sv
// Shared types and sizes for the CGRA integer reduction path.
// Lane width and phit geometry match the CGRA interface header.
package cgra_red_pkg;

  localparam int dwidth_double = 64;
  localparam int red_lanes     = 8;
  localparam int phit_size     = red_lanes * dwidth_double;
  localparam int RED_TREE_LAT  = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } red_state_t;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } red_tag_t;

endpackage

// File: rtl/Reduction_unit_int.sv
// 8-lane integer adder tree, three register stages.
// Sums wrap modulo 2^dwidth_double; no overflow detection.
module Reduction_unit_int
  import cgra_red_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [phit_size-1:0]     in1,
  output logic [dwidth_double-1:0] out1
);

  logic [3:0][dwidth_double-1:0] s1;
  logic [1:0][dwidth_double-1:0] s2;

  // Pairwise lane sums, then pairs of pairs, then the final total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      out1 <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        s1[i] <= in1[(2*i)*dwidth_double +: dwidth_double]
               + in1[(2*i+1)*dwidth_double +: dwidth_double];
      end
      for (int j = 0; j < 2; j++) begin
        s2[j] <= s1[2*j] + s1[2*j+1];
      end
      out1 <= s2[0] + s2[1];
    end
  end

endmodule

// File: rtl/reduction_stream_ctrl.sv
// Streams phits through the reduction tree and sums each message.
// One total and a saturating phit count are emitted per message.
module reduction_stream_ctrl
  import cgra_red_pkg::*;
#(
  parameter int TREE_LAT = RED_TREE_LAT,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [phit_size-1:0]     s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  input  logic                     flush,
  output logic [dwidth_double-1:0] m_data,
  output logic [CNT_W-1:0]         m_count,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy
);

  red_state_t state, state_nxt;
  red_tag_t   vpipe [TREE_LAT];
  red_tag_t   tag_out;

  logic                     hs;
  logic                     first_beat;
  logic                     last_exit;
  logic [phit_size-1:0]     tree_in;
  logic [dwidth_double-1:0] tree_out;
  logic [dwidth_double-1:0] acc;
  logic [dwidth_double-1:0] sum_nxt;
  logic [CNT_W-1:0]         cnt;

  assign hs         = s_valid && s_ready;
  assign first_beat = (state == IDLE);
  assign tree_in    = hs ? s_data : '0;
  assign tag_out    = vpipe[TREE_LAT-1];
  assign last_exit  = tag_out.v && tag_out.last;
  assign sum_nxt    = tag_out.first ? tree_out
                                    : acc + tree_out;

  Reduction_unit_int u_tree (
    .clk  (clk),
    .rst  (rst),
    .in1  (tree_in),
    .out1 (tree_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = s_last ? DRAIN : ACCUM;
      end
      ACCUM: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_exit) state_nxt = HOLD;
      end
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
    if (rst)   s_ready   = 1'b0;
  end

  // Tag pipe tracks tree occupancy; accumulator and counter follow it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TREE_LAT; i++) vpipe[i] <= '0;
      acc     <= '0;
      cnt     <= '0;
      m_data  <= '0;
      m_count <= '0;
    end else if (flush) begin
      for (int i = 0; i < TREE_LAT; i++) vpipe[i] <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      vpipe[0] <= hs ? red_tag_t'({1'b1, first_beat, s_last}) : '0;
      for (int i = 1; i < TREE_LAT; i++) vpipe[i] <= vpipe[i-1];
      if (hs) begin
        if (first_beat)     cnt <= CNT_W'(1);
        else if (cnt != '1) cnt <= cnt + 1'b1;
      end
      if (tag_out.v) begin
        acc <= sum_nxt;
        if (tag_out.last) begin
          m_data  <= sum_nxt;
          m_count <= cnt;
        end
      end
    end
  end

endmodule
